// File: rtl/core_sram_arbiter.sv
// core_sram_arbiter: merges the RV32 core's fetch and data ports onto one
// single-ported synchronous SRAM (1-cycle read latency). Data has fixed
// priority; a streak counter guarantees a waiting fetch gets a slot after
// MAX_DATA_STREAK consecutive data grants. Accesses outside the two valid
// regions (addr[31:24] == 8'h00 or 8'h80) never strobe the SRAM and return
// a one-cycle access fault instead.
module core_sram_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 24,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                       clock,
  input  logic                       RSTB,
  input  logic [31:0]                instruction_memoryAddress,
  input  logic                       instruction_memoryEnable,
  output logic [31:0]                instruction_memoryDataRead,
  output logic                       instruction_memoryBusy,
  output logic                       instruction_memoryAccessFault,
  input  logic [31:0]                data_memoryAddress,
  input  logic [3:0]                 data_memoryByteSelect,
  input  logic                       data_memoryEnable,
  input  logic                       data_memoryWriteEnable,
  input  logic [31:0]                data_memoryDataWrite,
  output logic [31:0]                data_memoryDataRead,
  output logic                       data_memoryBusy,
  output logic                       data_memoryAccessFault,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
  output logic [3:0]                 sram_byteSelect,
  output logic                       sram_enable,
  output logic                       sram_writeEnable,
  output logic [31:0]                sram_writeData,
  input  logic [31:0]                sram_readData
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic        inst_region_ok, data_region_ok;
  logic        grant_inst, grant_data;
  logic [3:0]  streak_q, streak_d;

  // Response tracking: what was accepted last cycle and how to answer it.
  logic        rsp_valid_q, rsp_port_q, rsp_read_q, rsp_fault_q;
  logic [3:0]  rsp_be_q;

  // Held read-data and fault registers per port.
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        inst_fault_q, data_fault_q;

  logic        inst_rsp_live, data_rsp_live;
  logic [31:0] data_lane_mask;

  assign inst_region_ok = (instruction_memoryAddress[31:24] == 8'h00) ||
                          (instruction_memoryAddress[31:24] == 8'h80);
  assign data_region_ok = (data_memoryAddress[31:24] == 8'h00) ||
                          (data_memoryAddress[31:24] == 8'h80);

  // Fixed data priority, except a waiting fetch wins once the streak is full.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (RSTB) begin
      if (data_memoryEnable && (!instruction_memoryEnable || streak_q != STREAK_MAX))
        grant_data = 1'b1;
      else if (instruction_memoryEnable)
        grant_inst = 1'b1;
    end
  end

  assign instruction_memoryBusy = instruction_memoryEnable && !grant_inst;
  assign data_memoryBusy        = data_memoryEnable && !grant_data;

  // Steer the granted port onto the SRAM; faulting requests never strobe it.
  always_comb begin
    sram_address     = '0;
    sram_byteSelect  = 4'b0000;
    sram_enable      = 1'b0;
    sram_writeEnable = 1'b0;
    if (grant_data) begin
      sram_address     = data_memoryAddress[SRAM_ADDR_WIDTH-1:0];
      sram_byteSelect  = data_memoryByteSelect;
      sram_enable      = data_region_ok;
      sram_writeEnable = data_memoryWriteEnable && data_region_ok;
    end else if (grant_inst) begin
      sram_address     = instruction_memoryAddress[SRAM_ADDR_WIDTH-1:0];
      sram_byteSelect  = 4'b1111;
      sram_enable      = inst_region_ok;
    end
  end

  assign sram_writeData = data_memoryDataWrite;

  // Count data grants taken while a fetch is waiting; any other cycle clears.
  always_comb begin
    streak_d = 4'd0;
    if (grant_data && instruction_memoryEnable && streak_q < STREAK_MAX)
      streak_d = streak_q + 4'd1;
  end

  // Byte-lane mask for data read returns; unselected lanes read as zero.
  always_comb begin
    data_lane_mask = '0;
    for (int k = 0; k < 4; k++)
      data_lane_mask[8*k +: 8] = {8{rsp_be_q[k]}};
  end

  // A valid read answered this cycle passes SRAM data straight through, so
  // the port sees it exactly one cycle after acceptance. Held off in reset
  // so a response pending at reset is never delivered.
  assign inst_rsp_live = RSTB && rsp_valid_q && !rsp_port_q && rsp_read_q && !rsp_fault_q;
  assign data_rsp_live = RSTB && rsp_valid_q &&  rsp_port_q && rsp_read_q && !rsp_fault_q;

  assign instruction_memoryDataRead = inst_rsp_live ? sram_readData : inst_rdata_q;
  assign data_memoryDataRead        = data_rsp_live ? (sram_readData & data_lane_mask)
                                                    : data_rdata_q;
  assign instruction_memoryAccessFault = inst_fault_q;
  assign data_memoryAccessFault        = data_fault_q;

  // Streak counter state.
  always_ff @(posedge clock) begin
    if (!RSTB) streak_q <= 4'd0;
    else       streak_q <= streak_d;
  end

  // Capture the accepted request so next cycle knows whom to answer and how.
  always_ff @(posedge clock) begin
    if (!RSTB) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_be_q    <= 4'b0000;
    end else begin
      rsp_valid_q <= grant_inst || grant_data;
      rsp_port_q  <= grant_data;
      rsp_read_q  <= grant_inst || !data_memoryWriteEnable;
      rsp_fault_q <= grant_data ? !data_region_ok : !inst_region_ok;
      rsp_be_q    <= grant_data ? data_memoryByteSelect : 4'b1111;
    end
  end

  // Fault flags: one-cycle pulse on the owning port after a faulting accept.
  always_ff @(posedge clock) begin
    if (!RSTB) begin
      inst_fault_q <= 1'b0;
      data_fault_q <= 1'b0;
    end else begin
      inst_fault_q <= grant_inst && !inst_region_ok;
      data_fault_q <= grant_data && !data_region_ok;
    end
  end

  // Held fetch data: latch the live read; a fault accept zeroes it.
  always_ff @(posedge clock) begin
    if (!RSTB) begin
      inst_rdata_q <= '0;
    end else if (grant_inst && !inst_region_ok) begin
      inst_rdata_q <= '0;
    end else if (inst_rsp_live) begin
      inst_rdata_q <= sram_readData;
    end
  end

  // Held data-port data: latch the masked read; faults and writes zero it.
  always_ff @(posedge clock) begin
    if (!RSTB) begin
      data_rdata_q <= '0;
    end else if (grant_data && (!data_region_ok || data_memoryWriteEnable)) begin
      data_rdata_q <= '0;
    end else if (data_rsp_live) begin
      data_rdata_q <= sram_readData & data_lane_mask;
    end
  end

endmodule

// File: tb/tb_core_sram_arbiter.sv
// Bench for core_sram_arbiter: a behavioural SRAM, a transaction-level
// reference model (grant rule, pending-response slot, word memory) and a
// set of directed scenarios followed by randomized traffic.
module tb_core_sram_arbiter;
  localparam int MAX = 4;

  logic        clock = 1'b0;
  logic        rstb;
  logic [31:0] faddr, daddr, dwd;
  logic        fen, den, dwe;
  logic [3:0]  dbe;
  logic [31:0] ird, drd;
  logic        ibusy, dbusy, ifault, dfault;
  logic [23:0] saddr;
  logic [3:0]  sbe;
  logic        sen, swe;
  logic [31:0] swd, srd;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  core_sram_arbiter #(.SRAM_ADDR_WIDTH(24), .MAX_DATA_STREAK(MAX)) dut (
    .clock(clock), .RSTB(rstb),
    .instruction_memoryAddress(faddr), .instruction_memoryEnable(fen),
    .instruction_memoryDataRead(ird), .instruction_memoryBusy(ibusy),
    .instruction_memoryAccessFault(ifault),
    .data_memoryAddress(daddr), .data_memoryByteSelect(dbe),
    .data_memoryEnable(den), .data_memoryWriteEnable(dwe),
    .data_memoryDataWrite(dwd), .data_memoryDataRead(drd),
    .data_memoryBusy(dbusy), .data_memoryAccessFault(dfault),
    .sram_address(saddr), .sram_byteSelect(sbe), .sram_enable(sen),
    .sram_writeEnable(swe), .sram_writeData(swd), .sram_readData(srd)
  );

  // ---------------- memories ----------------
  logic [31:0] sram_mem [int];
  logic [31:0] ref_mem  [int];

  function automatic logic [31:0] dflt(int idx);
    logic [31:0] t;
    t = 32'(idx);
    return (t * 32'h9E37_79B1) ^ 32'h0000_1357;
  endfunction

  function automatic logic [31:0] lanemask(logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  function automatic bit region_ok(logic [31:0] a);
    return (a[31:24] == 8'h00) || (a[31:24] == 8'h80);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int idx;
    idx = int'(a[23:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : dflt(idx);
  endfunction

  task automatic poke(logic [31:0] a, logic [31:0] v);
    sram_mem[int'(a[23:2])] = v;
    ref_mem[int'(a[23:2])]  = v;
  endtask

  // Behavioural single-port SRAM with registered read data.
  always @(posedge clock) begin
    if (sen) begin
      int idx;
      logic [31:0] w;
      idx = int'(saddr[23:2]);
      w = sram_mem.exists(idx) ? sram_mem[idx] : dflt(idx);
      if (swe) begin
        for (int k = 0; k < 4; k++) if (sbe[k]) w[8*k +: 8] = swd[8*k +: 8];
        sram_mem[idx] = w;
      end else begin
        srd <= w;
      end
    end
  end

  // ---------------- reference model ----------------
  int          streak = 0;
  logic [31:0] held_i = '0, held_d = '0, pend_val = '0;
  bit          pend_v = 0, pend_port = 0, pend_fault = 0;
  bit          m_dg, m_fg;
  logic        e_ibusy, e_dbusy, e_sen, e_swe, e_if, e_df;
  logic [3:0]  e_sbe;
  logic [23:0] e_saddr;
  logic [31:0] e_ird, e_drd;

  task automatic model_eval();
    m_dg = rstb && den && (!fen || streak != MAX);
    m_fg = rstb && fen && !m_dg;
    e_ibusy = fen && !m_fg;
    e_dbusy = den && !m_dg;
    e_sen   = (m_dg && region_ok(daddr)) || (m_fg && region_ok(faddr));
    e_swe   = m_dg && dwe && region_ok(daddr);
    e_sbe   = m_dg ? dbe : 4'hF;
    e_saddr = m_dg ? daddr[23:0] : faddr[23:0];
    e_ird   = (pend_v && !pend_port) ? pend_val : held_i;
    e_drd   = (pend_v &&  pend_port) ? pend_val : held_d;
    e_if    = pend_v && !pend_port && pend_fault;
    e_df    = pend_v &&  pend_port && pend_fault;
  endtask

  task automatic model_commit();
    logic [31:0] a, w;
    bit ok;
    model_eval();
    if (!rstb) begin
      streak = 0; held_i = '0; held_d = '0; pend_v = 0;
      return;
    end
    if (pend_v) begin
      if (pend_port) held_d = pend_val; else held_i = pend_val;
    end
    pend_v = 0;
    streak = (m_dg && fen) ? streak + 1 : 0;
    if (m_dg || m_fg) begin
      a  = m_dg ? daddr : faddr;
      ok = region_ok(a);
      pend_v = 1; pend_port = m_dg; pend_fault = !ok;
      if (!ok || (m_dg && dwe)) pend_val = '0;
      else if (m_fg)            pend_val = ref_rd(a);
      else                      pend_val = ref_rd(a) & lanemask(dbe);
      if (m_dg && dwe && ok) begin
        w = ref_rd(a);
        for (int k = 0; k < 4; k++) if (dbe[k]) w[8*k +: 8] = dwd[8*k +: 8];
        ref_mem[int'(a[23:2])] = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic drive(bit f, logic [31:0] fa, bit d, logic [31:0] da,
                       logic [3:0] be, bit we, logic [31:0] wd);
    fen = f; faddr = fa; den = d; daddr = da; dbe = be; dwe = we; dwd = wd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstb = 1'b0;
    drive(1, 32'h10, 1, 32'h100, 4'hF, 0, 0);
    repeat (2) begin
      @(negedge clock);
      checks++; if (ibusy !== 1'b1) begin errors++; $display("FAIL rst_ibusy got %b exp 1", ibusy); end
      checks++; if (dbusy !== 1'b1) begin errors++; $display("FAIL rst_dbusy got %b exp 1", dbusy); end
      checks++; if (sen !== 1'b0)   begin errors++; $display("FAIL rst_sen got %b exp 0", sen); end
      tick();
    end
    rstb = 1'b1;
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ird !== 32'h0) begin errors++; $display("FAIL rst_ird got %h exp 0", ird); end
    checks++; if (drd !== 32'h0) begin errors++; $display("FAIL rst_drd got %h exp 0", drd); end
    checks++; if ({ifault, dfault} !== 2'b00) begin errors++; $display("FAIL rst_faults got %b exp 00", {ifault, dfault}); end
    tick();
  endtask

  task automatic test_fetch_only();
    poke(32'h10, 32'h0000_0413);
    drive(1, 32'h0000_0010, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ibusy !== 1'b0) begin errors++; $display("FAIL fetch_busy got %b exp 0", ibusy); end
    checks++; if (sbe !== 4'b1111) begin errors++; $display("FAIL fetch_sbe got %b exp 1111", sbe); end
    checks++; if (sen !== 1'b1 || swe !== 1'b0) begin errors++; $display("FAIL fetch_strobe got en=%b we=%b exp en=1 we=0", sen, swe); end
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ird !== 32'h0000_0413) begin errors++; $display("FAIL fetch_data got %h exp 00000413", ird); end
    tick();
  endtask

  task automatic test_contention();
    poke(32'h8000_0100, 32'hDEAD_BEEF);
    drive(1, 32'h20, 1, 32'h8000_0100, 4'b0011, 0, 0);
    @(negedge clock);
    checks++; if (ibusy !== 1'b1) begin errors++; $display("FAIL cont_ibusy got %b exp 1", ibusy); end
    checks++; if (dbusy !== 1'b0) begin errors++; $display("FAIL cont_dbusy got %b exp 0", dbusy); end
    tick();
    drive(1, 32'h20, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (drd !== 32'h0000_BEEF) begin errors++; $display("FAIL cont_drd got %h exp 0000beef", drd); end
    checks++; if (ibusy !== 1'b0) begin errors++; $display("FAIL cont_fetch_next got busy=%b exp 0", ibusy); end
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ird !== dflt(32'h20 >> 2)) begin errors++; $display("FAIL cont_ird got %h exp %h", ird, dflt(32'h20 >> 2)); end
    checks++; if (drd !== 32'h0000_BEEF) begin errors++; $display("FAIL cont_drd_hold got %h exp 0000beef", drd); end
    tick();
  endtask

  task automatic test_streak();
    for (int c = 0; c < 6; c++) begin
      drive(1, 32'h30, 1, 32'h100 + 32'(c * 4), 4'hF, 0, 0);
      @(negedge clock);
      if (c == 4) begin
        checks++; if (dbusy !== 1'b1 || ibusy !== 1'b0) begin errors++; $display("FAIL streak_fetch c=%0d got d=%b i=%b exp d=1 i=0", c, dbusy, ibusy); end
      end else begin
        checks++; if (dbusy !== 1'b0 || ibusy !== 1'b1) begin errors++; $display("FAIL streak_data c=%0d got d=%b i=%b exp d=0 i=1", c, dbusy, ibusy); end
      end
      tick();
    end
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    tick();
  endtask

  task automatic test_fault_write();
    drive(0, 0, 1, 32'h4000_0000, 4'hF, 1, 32'hCAFE_F00D);
    @(negedge clock);
    checks++; if (sen !== 1'b0 || dbusy !== 1'b0) begin errors++; $display("FAIL flt_strobe got en=%b busy=%b exp 0 0", sen, dbusy); end
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (dfault !== 1'b1 || ifault !== 1'b0) begin errors++; $display("FAIL flt_pulse got d=%b i=%b exp d=1 i=0", dfault, ifault); end
    checks++; if (drd !== 32'h0) begin errors++; $display("FAIL flt_drd got %h exp 0", drd); end
    tick();
    @(negedge clock);
    checks++; if (dfault !== 1'b0) begin errors++; $display("FAIL flt_one_cycle got %b exp 0", dfault); end
    tick();
  endtask

  task automatic test_write();
    logic [31:0] exp_rb;
    drive(0, 0, 1, 32'h0000_2000, 4'b1000, 1, 32'h1234_5678);
    @(negedge clock);
    checks++; if (swe !== 1'b1 || sen !== 1'b1) begin errors++; $display("FAIL wr_strobe got en=%b we=%b exp 1 1", sen, swe); end
    checks++; if (sbe !== 4'b1000) begin errors++; $display("FAIL wr_sbe got %b exp 1000", sbe); end
    checks++; if (swd !== 32'h1234_5678 || saddr !== 24'h002000) begin errors++; $display("FAIL wr_bus got d=%h a=%h exp 12345678 002000", swd, saddr); end
    tick();
    drive(0, 0, 1, 32'h0000_2000, 4'hF, 0, 0);
    @(negedge clock);
    checks++; if (drd !== 32'h0 || dfault !== 1'b0) begin errors++; $display("FAIL wr_rsp got %h f=%b exp 0 f=0", drd, dfault); end
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    exp_rb = (dflt(32'h2000 >> 2) & 32'h00FF_FFFF) | 32'h1200_0000;
    @(negedge clock);
    checks++; if (drd !== exp_rb) begin errors++; $display("FAIL wr_readback got %h exp %h", drd, exp_rb); end
    tick();
  endtask

  task automatic test_reset_pending();
    drive(1, 32'h24, 1, 32'h8000_0200, 4'hF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    rstb = 1'b0;
    @(negedge clock);
    checks++; if (sen !== 1'b0) begin errors++; $display("FAIL rstp_sen got %b exp 0", sen); end
    tick();
    rstb = 1'b1;
    @(negedge clock);
    checks++; if (ird !== 32'h0 || drd !== 32'h0) begin errors++; $display("FAIL rstp_data got i=%h d=%h exp 0 0", ird, drd); end
    checks++; if ({ifault, dfault} !== 2'b00) begin errors++; $display("FAIL rstp_faults got %b exp 00", {ifault, dfault}); end
    drive(1, 32'h10, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ibusy !== 1'b0) begin errors++; $display("FAIL rstp_fetch_busy got %b exp 0", ibusy); end
    tick();
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clock);
    checks++; if (ird !== 32'h0000_0413) begin errors++; $display("FAIL rstp_fetch got %h exp 00000413", ird); end
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] reg_hi;
    case ($urandom_range(0, 5))
      0, 1:    reg_hi = 8'h00;
      2, 3:    reg_hi = 8'h80;
      4:       reg_hi = 8'h40;
      default: reg_hi = 8'hFF;
    endcase
    return {reg_hi, 16'h0000, 8'($urandom_range(0, 15) << 2)};
  endfunction

  task automatic test_random(int n);
    bit hold_i = 0, hold_d = 0;
    for (int c = 0; c < n; c++) begin
      if (!hold_i) begin fen = ($urandom_range(0, 3) != 0); faddr = rand_addr(); end
      if (!hold_d) begin
        den = ($urandom_range(0, 3) != 0); daddr = rand_addr();
        dbe = 4'($urandom_range(1, 15)); dwe = $urandom_range(0, 2) == 0; dwd = $urandom;
      end
      @(negedge clock);
      model_eval();
      checks++; if (ibusy !== e_ibusy) begin errors++; $display("FAIL rnd_ibusy c=%0d got %b exp %b", c, ibusy, e_ibusy); end
      checks++; if (dbusy !== e_dbusy) begin errors++; $display("FAIL rnd_dbusy c=%0d got %b exp %b", c, dbusy, e_dbusy); end
      checks++; if (sen !== e_sen) begin errors++; $display("FAIL rnd_sen c=%0d got %b exp %b", c, sen, e_sen); end
      checks++; if (swe !== e_swe) begin errors++; $display("FAIL rnd_swe c=%0d got %b exp %b", c, swe, e_swe); end
      if (e_sen) begin
        checks++; if (sbe !== e_sbe || saddr !== e_saddr) begin errors++; $display("FAIL rnd_sbus c=%0d got be=%b a=%h exp be=%b a=%h", c, sbe, saddr, e_sbe, e_saddr); end
      end
      checks++; if (ird !== e_ird) begin errors++; $display("FAIL rnd_ird c=%0d got %h exp %h", c, ird, e_ird); end
      checks++; if (drd !== e_drd) begin errors++; $display("FAIL rnd_drd c=%0d got %h exp %h", c, drd, e_drd); end
      checks++; if (ifault !== e_if || dfault !== e_df) begin errors++; $display("FAIL rnd_fault c=%0d got i=%b d=%b exp i=%b d=%b", c, ifault, dfault, e_if, e_df); end
      hold_i = e_ibusy;
      hold_d = e_dbusy;
      tick();
    end
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 0, 4'h0, 0, 0);
    rstb = 1'b0;
    #1;
    test_reset();
    test_fetch_only();
    test_contention();
    test_streak();
    test_fault_write();
    test_write();
    test_reset_pending();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
